// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mips_mem_pkg;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;
  localparam logic [3:0] MEM_BE_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } arb_state_t;

  // Fields presented to memory for the transaction in flight.
  typedef struct packed {
    logic              we;
    logic [3:0]        be;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_fairness_counter.sv
// Counts consecutive data grants made while a fetch is waiting; saturates at MAX_D.
module arb_fairness_counter
  import mips_mem_pkg::*;
#(
  parameter int MAX_D = 4,
  localparam int CW = $clog2(MAX_D + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] starve_cnt,
  output logic          limit_hit
);

  logic [CW-1:0] cnt_reg;

  assign starve_cnt = cnt_reg;
  assign limit_hit  = (cnt_reg == CW'(MAX_D));

  // Clear has priority over increment; increment stops at the limit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && !limit_hit) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the data stage.
// One transaction in flight; data wins unless fetch has been starved MAX_D times.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW    = MEM_AW,
  parameter int DW    = MEM_DW,
  parameter int MAX_D = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  output logic          i_valid,
  output logic [DW-1:0] i_rdata,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_D + 1);

  arb_state_t    state_reg, state_next;
  mem_req_t      req_reg, req_next;
  logic          drop_reg, drop_next;
  logic          i_valid_reg, i_valid_next;
  logic          d_valid_reg, d_valid_next;
  logic [DW-1:0] i_rdata_reg, i_rdata_next;
  logic [DW-1:0] d_rdata_reg, d_rdata_next;

  logic          eligible_i, eligible_d;
  logic          grant_i, grant_d;
  logic [CW-1:0] starve_cnt;
  logic          limit_hit;

  // A requester whose completion pulse is showing this cycle sits out the grant.
  assign eligible_i = i_req & ~i_flush & ~i_valid_reg;
  assign eligible_d = d_req & ~d_valid_reg;

  arb_fairness_counter #(.MAX_D(MAX_D)) u_fairness (
    .clk        (clk),
    .reset      (reset),
    .inc        (grant_d & i_req & ~limit_hit),
    .clr        (grant_i | ~i_req),
    .starve_cnt (starve_cnt),
    .limit_hit  (limit_hit)
  );

  // Next-state, grant selection, request mux and response capture.
  always_comb begin
    state_next   = state_reg;
    req_next     = req_reg;
    drop_next    = drop_reg;
    i_valid_next = 1'b0;
    d_valid_next = 1'b0;
    i_rdata_next = i_rdata_reg;
    d_rdata_next = d_rdata_reg;
    grant_i      = 1'b0;
    grant_d      = 1'b0;

    case (state_reg)
      IDLE: begin
        drop_next = 1'b0;
        if (eligible_d && (!eligible_i || (starve_cnt < CW'(MAX_D)))) begin
          grant_d        = 1'b1;
          state_next     = D_WAIT;
          req_next.we    = d_we;
          req_next.be    = d_we ? d_be : MEM_BE_ALL;
          req_next.addr  = d_addr;
          req_next.wdata = d_we ? d_wdata : '0;
        end else if (eligible_i) begin
          grant_i        = 1'b1;
          state_next     = I_WAIT;
          req_next.we    = 1'b0;
          req_next.be    = MEM_BE_ALL;
          req_next.addr  = i_addr;
          req_next.wdata = '0;
        end
      end

      I_WAIT: begin
        if (mem_ready) begin
          state_next = IDLE;
          drop_next  = 1'b0;
          // A flush now or earlier means the fetched word is stale: finish silently.
          if (!drop_reg && !i_flush) begin
            i_valid_next = 1'b1;
            i_rdata_next = mem_rdata;
          end
        end else if (i_flush) begin
          drop_next = 1'b1;
        end
      end

      D_WAIT: begin
        if (mem_ready) begin
          state_next   = IDLE;
          d_valid_next = 1'b1;
          d_rdata_next = req_reg.we ? '0 : mem_rdata;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, request and response registers; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      req_reg     <= '0;
      drop_reg    <= 1'b0;
      i_valid_reg <= 1'b0;
      d_valid_reg <= 1'b0;
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      req_reg     <= req_next;
      drop_reg    <= drop_next;
      i_valid_reg <= i_valid_next;
      d_valid_reg <= d_valid_next;
      i_rdata_reg <= i_rdata_next;
      d_rdata_reg <= d_rdata_next;
    end
  end

  assign mem_req   = (state_reg != IDLE);
  assign mem_we    = req_reg.we;
  assign mem_be    = req_reg.be;
  assign mem_addr  = req_reg.addr;
  assign mem_wdata = req_reg.wdata;

  assign i_valid = i_valid_reg;
  assign i_rdata = i_rdata_reg;
  assign d_valid = d_valid_reg;
  assign d_rdata = d_rdata_reg;
  assign i_stall = i_req & ~i_valid_reg;
  assign d_stall = d_req & ~d_valid_reg;

endmodule
